// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read/status bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             wreq;
    logic [DSIZE-1:0] wdata;
    logic             full;
    logic             almost_full;
    logic             rreq;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             empty;
    logic             almost_empty;
    logic [ASIZE:0]   count;
    logic             clr_err;
    logic             ovf;
    logic             udf;

    // Producer/consumer side: issues requests, observes data and status
    modport master (
        output wreq, wdata, rreq, clr_err,
        input  full, almost_full, rdata, rvalid, empty, almost_empty, count, ovf, udf
    );

    // FIFO side
    modport slave (
        input  wreq, wdata, rreq, clr_err,
        output full, almost_full, rdata, rvalid, empty, almost_empty, count, ovf, udf
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with thresholds, sticky errors and optional FWFT read
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  fifo
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_V  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_V = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wr_ptr;
    logic [ASIZE:0]   rd_ptr;
    logic [ASIZE:0]   occ;
    logic             is_empty;
    logic             is_full;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_q;
    logic             udf_q;
    logic [DSIZE-1:0] rdata_o;
    logic             rvalid_o;

    // Status comes only from registered pointers, so a same-cycle read
    // never makes room for a same-cycle write and vice versa.
    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]) &&
                      (wr_ptr[ASIZE] != rd_ptr[ASIZE]);
    assign occ      = wr_ptr - rd_ptr;

    // Reset overrides any request presented in the same cycle.
    assign wr_en = fifo.wreq & ~is_full & ~rst;
    assign rd_en = fifo.rreq & ~is_empty & ~rst;

    // Storage array; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ASIZE-1:0]] <= fifo.wdata;
        end
    end

    // Write and read pointers, wrap bit in the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (fifo.wreq && is_full) begin
                ovf_q <= 1'b1;
            end else if (fifo.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (fifo.rreq && is_empty) begin
                udf_q <= 1'b1;
            end else if (fifo.clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always displayed; rreq pops it
            always_comb begin
                rdata_o  = mem[rd_ptr[ASIZE-1:0]];
                rvalid_o = ~is_empty;
            end
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            logic             rvalid_q;

            // Registered read: one-cycle rvalid pulse, rdata holds between reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_en;
                    if (rd_en) begin
                        rdata_q <= mem[rd_ptr[ASIZE-1:0]];
                    end
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end
    endgenerate

    assign fifo.empty        = is_empty;
    assign fifo.full         = is_full;
    assign fifo.count        = occ;
    assign fifo.almost_full  = (occ >= AFULL_V);
    assign fifo.almost_empty = (occ <= AEMPTY_V);
    assign fifo.ovf          = ovf_q;
    assign fifo.udf          = udf_q;
    assign fifo.rdata        = rdata_o;
    assign fifo.rvalid       = rvalid_o;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench running registered and FWFT builds in lockstep
module tb_sync_fifo_param;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) f0 ();
    sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) f1 ();

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0))
        dut0 (.clk(clk), .rst(rst), .fifo(f0));
    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1))
        dut1 (.clk(clk), .rst(rst), .fifo(f1));

    // Reference model: FIFO contents as a queue plus sticky flags
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_udf;
    bit         started;
    int         n_total;
    int         n_pass;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endfunction

    task automatic check_status();
        int sz;
        sz = mq.size();
        chk("count0", 32'(f0.count), 32'(sz));
        chk("count1", 32'(f1.count), 32'(sz));
        chk("empty0", 32'(f0.empty), 32'(sz == 0));
        chk("empty1", 32'(f1.empty), 32'(sz == 0));
        chk("full0", 32'(f0.full), 32'(sz == DEPTH));
        chk("full1", 32'(f1.full), 32'(sz == DEPTH));
        chk("afull0", 32'(f0.almost_full), 32'(sz >= 12));
        chk("afull1", 32'(f1.almost_full), 32'(sz >= 12));
        chk("aempty0", 32'(f0.almost_empty), 32'(sz <= 2));
        chk("aempty1", 32'(f1.almost_empty), 32'(sz <= 2));
        chk("ovf0", 32'(f0.ovf), 32'(m_ovf));
        chk("ovf1", 32'(f1.ovf), 32'(m_ovf));
        chk("udf0", 32'(f0.udf), 32'(m_udf));
        chk("udf1", 32'(f1.udf), 32'(m_udf));
    endtask

    // One clock of stimulus applied to both builds, then model update and status check
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
        bit wa, ra, was_full, was_empty;
        f0.wreq = w; f0.wdata = d; f0.rreq = r; f0.clr_err = c;
        f1.wreq = w; f1.wdata = d; f1.rreq = r; f1.clr_err = c;
        rst = rs;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        wa = w && !was_full;
        ra = r && !was_empty;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (ra) begin
                exp_q.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (wa) mq.push_back(d);
            if (w && was_full) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (r && was_empty) m_udf = 1;
            else if (c) m_udf = 0;
        end
        #1;
        check_status();
    endtask

    // Monitor: registered build pops the scoreboard on rvalid; FWFT build shows the model head
    always @(negedge clk) begin
        if (started) begin
            chk("rvalid0", 32'(f0.rvalid), 32'(exp_q.size() != 0));
            if (f0.rvalid === 1'b1 && exp_q.size() != 0) begin
                chk("rdata0", 32'(f0.rdata), 32'(exp_q.pop_front()));
            end
            chk("rvalid1", 32'(f1.rvalid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rdata1", 32'(f1.rdata), 32'(mq[0]));
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        started = 0;
        m_ovf   = 0;
        m_udf   = 0;

        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("rst_rdata0", 32'(f0.rdata), 32'h0);
        started = 1;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        // Write while full is dropped and flags ovf, then clear
        step(1, 8'hAA, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        // Drain in order, then one read too many
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);

        // Prefill 5, then 40 cycles of simultaneous write/read across pointer wrap
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 8'(8'h45 + i), 1, 0, 0);
        while (mq.size() != 0) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Single word into empty FIFO: FWFT build shows it without rreq
        step(1, 8'h5A, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Same-cycle write+read on empty and on full
        step(1, 8'h11, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(1, 8'hEE, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0);

        // Overflow, drain to 7, then reset with a pending write
        step(1, 8'h77, 0, 0, 0);
        step(1, 8'h78, 0, 0, 0);
        while (mq.size() > 7) step(0, 8'h00, 1, 0, 0);
        step(1, 8'hC3, 0, 0, 1);
        chk("rst_count_after", 32'(f0.count), 32'h0);
        step(0, 8'h00, 0, 0, 0);

        // Error set coinciding with clr_err keeps the flag
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            bit w, r, c, rs;
            int bias;
            bias = (i / 300) % 3;
            w  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
            r  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            c  = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(w, 8'($urandom_range(0, 255)), r, c, rs);
        end

        step(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the team's dual-clock Gray-pointer FIFO, for buffering where producer and consumer share one clock domain. Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. Sits between stream producers and consumers inside one clock domain; no CDC logic.

## Interface
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; depth = 2^ASIZE entries
- AFULL_TH, 12, almost_full asserted when count >= AFULL_TH (1..2^ASIZE)
- AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (0..2^ASIZE-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word fall-through

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wreq  in  1  write request
- wdata  in  DSIZE  write data
- full  out  1  FIFO holds 2^ASIZE words
- almost_full  out  1  count >= AFULL_TH
- rreq  in  1  read request (FWFT=1: pop head word)
- rdata  out  DSIZE  read data
- rvalid  out  1  rdata valid
- empty  out  1  FIFO holds 0 words
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  ASIZE+1  current occupancy, 0..2^ASIZE
- clr_err  in  1  clears ovf/udf
- ovf  out  1  sticky: write attempted while full
- udf  out  1  sticky: read attempted while empty

## Operation
- Storage: 2^ASIZE x DSIZE register array, not reset.
- Pointers wr_ptr, rd_ptr: ASIZE+1-bit binary; low ASIZE bits address memory, MSB is wrap bit; both wrap modulo 2^(ASIZE+1).
- empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ; count = wr_ptr - rd_ptr (ASIZE+1-bit modular).
- Write accepted iff wreq & ~full: mem[wr_ptr] <= wdata, wr_ptr++.
- Read accepted iff rreq & ~empty: rd_ptr++.
- Flags/count are evaluated on current registered state only; a same-cycle read never frees space for a same-cycle write, and a same-cycle write never supplies a same-cycle read.
  - full & wreq & rreq: read accepted, write dropped, ovf set.
  - empty & wreq & rreq: write accepted, read rejected, udf set.
  - neither full nor empty, both requests: both accepted, count unchanged.
- ovf <= 1 on wreq & full; udf <= 1 on rreq & empty; both hold until clr_err or rst. If clr_err coincides with a new error, the error wins (flag stays 1).
- FWFT=0: on accepted read, rdata <= mem[rd_ptr], rvalid <= 1 for one cycle; otherwise rvalid <= 0, rdata holds last value.
- FWFT=1: rdata = mem[rd_ptr[ASIZE-1:0]] combinationally, rvalid = ~empty; rreq acknowledges/pops the displayed word.
- rst: pointers 0, rdata 0, rvalid 0, ovf/udf 0; hence empty=1, almost_empty=1, full=0, almost_full=0, count=0. Reset overrides all requests in that cycle; mid-operation reset discards contents.

## Timing
- full, empty, almost_*, count reflect an accepted operation on the edge after it (registered-pointer-based, no combinational path from wreq/rreq).
- FWFT=0 read latency: 1 cycle (rreq at edge N -> rdata/rvalid valid after edge N+1... i.e. sampled at edge N, visible until edge N+1).
- FWFT=1: word written at edge N visible on rdata with rvalid=1 after edge N.
- Write-to-read minimum: a word written at edge N is readable at edge N+1.
- Full throughput: one write and one read per cycle sustained when 0 < count < 2^ASIZE.

## Test plan
- Reset, then write 0x00..0x0F on 16 consecutive cycles (defaults) -> almost_full rises after 12th write, full=1 and count=16 after 16th; empty=0 after first.
- With FIFO full, wreq with 0xAA -> write dropped, count stays 16, ovf=1 next cycle; pulse clr_err -> ovf=0.
- FWFT=0, read 16 consecutive cycles -> rdata 0x00..0x0F in order, rvalid=1 one cycle after each rreq, empty=1 after 16th; extra rreq -> udf=1, rvalid=0.
- Prefill 5 words, then simultaneous wreq/rreq for 40 cycles with incrementing data -> count holds 5, data order preserved across pointer wrap (>32 writes), no ovf/udf.
- FWFT=1 build: write 0x5A into empty FIFO -> next cycle rdata=0x5A, rvalid=1 without rreq; rreq -> rvalid=0, empty=1 next cycle.
- At count=7 with ovf=1, assert rst for one cycle with wreq=1 -> next cycle count=0, empty=1, rvalid=0, ovf=0, write ignored.
